// File: rtl/processor_gen_if.sv
// Bus-side bundle of the processor: instruction/data in, start, done, bus view.
// The core uses the slave modport; the driving environment uses master.
interface processor_gen_if #(
  parameter int N = 16
);
  logic [N-1:0] DIN;
  logic         Run;
  logic         Done;
  logic [N-1:0] BusWires;

  modport slave (
    input  DIN,
    input  Run,
    output Done,
    output BusWires
  );

  modport master (
    output DIN,
    output Run,
    input  Done,
    input  BusWires
  );
endinterface

// File: rtl/processor_gen.sv
// Multi-cycle bus-based processor: eight GPRs, A/G accumulators, 10-bit IR.
// Four-step controller T0..T3 drives a single shared bus and an 8-op ALU.
module processor_gen #(
  parameter int N   = 16,
  parameter int SHW = 4
) (
  input logic            Clock,
  input logic            Reset,
  processor_gen_if.slave bus
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
  typedef enum logic [1:0] {
    SEL_DIN, SEL_RX, SEL_RY, SEL_G
  } sel_t;

  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_MVI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_MVNZ = 4'd10;

  localparam logic [N-1:0] LP_N = N'(N);

  state_t         r_state;
  state_t         w_next;
  logic [N-1:0]   r_reg [8];
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_g;
  logic [9:0]     r_ir;

  logic [3:0]     w_op;
  logic [2:0]     w_x;
  logic [2:0]     w_y;
  logic [N-1:0]   w_rx;
  logic [N-1:0]   w_ry;
  logic           w_is_alu;
  logic           w_gnz;

  logic           w_done;
  logic           w_ir_we;
  logic           w_a_we;
  logic           w_g_we;
  logic           w_rx_we;
  sel_t           w_sel;
  logic [N-1:0]   w_bus;
  logic [N-1:0]   w_alu;
  logic [SHW-1:0] w_shamt;
  logic           w_shbig;
  logic           w_lt;

  assign w_op     = r_ir[9:6];
  assign w_x      = r_ir[5:3];
  assign w_y      = r_ir[2:0];
  assign w_rx     = r_reg[w_x];
  assign w_ry     = r_reg[w_y];
  assign w_is_alu = (w_op >= OP_ADD) && (w_op <= OP_XOR);
  assign w_gnz    = |r_g;

  // FSM state register; reset aborts any instruction in flight
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= T0;
    else       r_state <= w_next;
  end

  // FSM next state: short ops end in T1, ALU ops run through T3
  always_comb begin
    w_next = T0;
    case (r_state)
      T0:      w_next = bus.Run ? T1 : T0;
      T1:      w_next = w_is_alu ? T2 : T0;
      T2:      w_next = T3;
      default: w_next = T0;
    endcase
  end

  // FSM outputs: register enables, bus source and Done per step
  always_comb begin
    w_done  = 1'b0;
    w_ir_we = 1'b0;
    w_a_we  = 1'b0;
    w_g_we  = 1'b0;
    w_rx_we = 1'b0;
    w_sel   = SEL_DIN;
    case (r_state)
      T0: w_ir_we = bus.Run;
      T1: begin
        if (w_is_alu) begin
          w_sel  = SEL_RX;
          w_a_we = 1'b1;
        end else begin
          w_done = 1'b1;
          case (w_op)
            OP_MV: begin
              w_sel   = SEL_RY;
              w_rx_we = 1'b1;
            end
            OP_MVI: begin
              w_sel   = SEL_DIN;
              w_rx_we = 1'b1;
            end
            OP_MVNZ: begin
              w_sel   = SEL_RY;
              w_rx_we = w_gnz;
            end
            default: w_sel = SEL_DIN;
          endcase
        end
      end
      T2: begin
        w_sel  = SEL_RY;
        w_g_we = 1'b1;
      end
      default: begin
        w_sel   = SEL_G;
        w_rx_we = 1'b1;
        w_done  = 1'b1;
      end
    endcase
  end

  // Shared bus multiplexer; DIN is the idle source
  always_comb begin
    w_bus = bus.DIN;
    case (w_sel)
      SEL_RX:  w_bus = w_rx;
      SEL_RY:  w_bus = w_ry;
      SEL_G:   w_bus = r_g;
      default: w_bus = bus.DIN;
    endcase
  end

  assign w_shamt = w_bus[SHW-1:0];
  assign w_shbig = (w_bus >= LP_N);
  assign w_lt    = $signed(r_a) < $signed(w_bus);

  // ALU: second operand is RY, which is on the bus during T2
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD: w_alu = r_a + w_bus;
      OP_SUB: w_alu = r_a - w_bus;
      OP_OR:  w_alu = r_a | w_bus;
      OP_SLT: w_alu = {{(N-1){1'b0}}, w_lt};
      OP_SLL: w_alu = w_shbig ? '0 : (r_a << w_shamt);
      OP_SRL: w_alu = w_shbig ? '0 : (r_a >> w_shamt);
      OP_AND: w_alu = r_a & w_bus;
      OP_XOR: w_alu = r_a ^ w_bus;
      default: w_alu = '0;
    endcase
  end

  // Datapath registers; every RX write takes its value from the bus
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) r_reg[i] <= '0;
      r_a  <= '0;
      r_g  <= '0;
      r_ir <= '0;
    end else begin
      if (w_ir_we) r_ir <= bus.DIN[N-1 -: 10];
      if (w_a_we)  r_a  <= w_bus;
      if (w_g_we)  r_g  <= w_alu;
      if (w_rx_we) r_reg[w_x] <= w_bus;
    end
  end

  assign bus.Done     = w_done;
  assign bus.BusWires = w_bus;

endmodule

// File: tb/tb_processor_gen.sv
// Directed bench for processor_gen (N=16): registers are observed on the bus
// via mv Rr,Rr (RY on bus in T1) and ALU results via G on the bus in T3.
module tb_processor_gen;

  logic Clock;
  logic Reset;
  int   n_pass;
  int   n_tot;

  processor_gen_if #(.N(16)) bus_if ();

  processor_gen #(.N(16), .SHW(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_if)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [15:0] enc(
    input logic [3:0] op, input logic [2:0] x, input logic [2:0] y);
    return {op, x, y, 6'b0};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc(input logic [15:0] din, input logic run,
                     input logic edone, input logic [15:0] ebus,
                     input string tag);
    @(negedge Clock);
    bus_if.DIN = din;
    bus_if.Run = run;
    #1;
    chk({tag, ".done"}, {15'b0, bus_if.Done}, {15'b0, edone});
    chk({tag, ".bus"}, bus_if.BusWires, ebus);
  endtask

  task automatic mvi(input logic [2:0] x, input logic [15:0] v);
    cyc(enc(4'd1, x, 3'd0), 1'b1, 1'b0, enc(4'd1, x, 3'd0), "mvi.t0");
    cyc(v, 1'b0, 1'b1, v, "mvi.t1");
  endtask

  task automatic peek(input logic [2:0] r, input logic [15:0] e,
                      input string tag);
    cyc(enc(4'd0, r, r), 1'b1, 1'b0, enc(4'd0, r, r), {tag, ".t0"});
    cyc(16'hBEEF, 1'b0, 1'b1, e, tag);
  endtask

  task automatic short(input logic [3:0] op, input logic [2:0] x,
                       input logic [2:0] y, input logic [15:0] eb,
                       input string tag);
    cyc(enc(op, x, y), 1'b1, 1'b0, enc(op, x, y), {tag, ".t0"});
    cyc(16'hFFFF, 1'b0, 1'b1, eb, {tag, ".t1"});
  endtask

  // Run held high in T1..T3 must be ignored
  task automatic alu(input logic [3:0] op, input logic [2:0] x,
                     input logic [2:0] y, input logic [15:0] erx,
                     input logic [15:0] ery, input logic [15:0] eg,
                     input string tag);
    cyc(enc(op, x, y), 1'b1, 1'b0, enc(op, x, y), {tag, ".t0"});
    cyc(16'hFFFF, 1'b1, 1'b0, erx, {tag, ".t1"});
    cyc(16'hFFFF, 1'b1, 1'b0, ery, {tag, ".t2"});
    cyc(16'hFFFF, 1'b1, 1'b1, eg, {tag, ".t3"});
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    Reset  = 1'b1;
    bus_if.DIN = 16'h1234;
    bus_if.Run = 1'b0;
    #2;
    chk("rst.done", {15'b0, bus_if.Done}, 16'h0);
    chk("rst.bus", bus_if.BusWires, 16'h1234);
    #1;
    Reset = 1'b0;
    cyc(16'h5678, 1'b0, 1'b0, 16'h5678, "idle");
    peek(3'd0, 16'h0000, "rst.r0");
    peek(3'd3, 16'h0000, "rst.r3");

    cyc(16'h1000, 1'b1, 1'b0, 16'h1000, "v30.t0");
    cyc(16'h0005, 1'b0, 1'b1, 16'h0005, "v30.t1");
    cyc(16'h1200, 1'b1, 1'b0, 16'h1200, "v30b.t0");
    cyc(16'h0003, 1'b0, 1'b1, 16'h0003, "v30b.t1");
    peek(3'd0, 16'h0005, "r0.5");
    peek(3'd1, 16'h0003, "r1.3");

    alu(4'd2, 3'd0, 3'd1, 16'h0005, 16'h0003, 16'h0008, "add");
    peek(3'd0, 16'h0008, "r0.8");

    mvi(3'd2, 16'h0000);
    mvi(3'd3, 16'h0001);
    alu(4'd3, 3'd2, 3'd3, 16'h0000, 16'h0001, 16'hFFFF, "sub");
    peek(3'd2, 16'hFFFF, "r2.ffff");

    mvi(3'd4, 16'hFFFF);
    mvi(3'd5, 16'h0001);
    alu(4'd5, 3'd4, 3'd5, 16'hFFFF, 16'h0001, 16'h0001, "slt.t");
    peek(3'd4, 16'h0001, "r4.1");
    mvi(3'd4, 16'hFFFF);
    alu(4'd5, 3'd5, 3'd4, 16'h0001, 16'hFFFF, 16'h0000, "slt.f");
    peek(3'd5, 16'h0000, "r5.0");

    mvi(3'd6, 16'h0001);
    mvi(3'd7, 16'd16);
    alu(4'd6, 3'd6, 3'd7, 16'h0001, 16'd16, 16'h0000, "sll16");
    peek(3'd6, 16'h0000, "r6.0");
    mvi(3'd6, 16'h0001);
    mvi(3'd7, 16'd4);
    alu(4'd6, 3'd6, 3'd7, 16'h0001, 16'h0004, 16'h0010, "sll4");
    alu(4'd7, 3'd6, 3'd7, 16'h0010, 16'h0004, 16'h0001, "srl4");
    peek(3'd6, 16'h0001, "r6.1");

    mvi(3'd2, 16'h00F0);
    mvi(3'd3, 16'h0FF0);
    alu(4'd4, 3'd2, 3'd3, 16'h00F0, 16'h0FF0, 16'h0FF0, "or");
    alu(4'd8, 3'd2, 3'd3, 16'h0FF0, 16'h0FF0, 16'h0FF0, "and");
    alu(4'd9, 3'd2, 3'd3, 16'h0FF0, 16'h0FF0, 16'h0000, "xor");

    mvi(3'd0, 16'h0AAA);
    mvi(3'd1, 16'h0555);
    short(4'd10, 3'd0, 3'd1, 16'h0555, "mvnz.g0");
    peek(3'd0, 16'h0AAA, "r0.keep");
    alu(4'd2, 3'd2, 3'd3, 16'h0000, 16'h0FF0, 16'h0FF0, "add.g");
    short(4'd10, 3'd0, 3'd1, 16'h0555, "mvnz.g1");
    peek(3'd0, 16'h0555, "r0.mv");

    alu(4'd2, 3'd1, 3'd1, 16'h0555, 16'h0555, 16'h0AAA, "addxx");
    peek(3'd1, 16'h0AAA, "r1.aaa");

    short(4'd15, 3'd0, 3'd1, 16'hFFFF, "rsvd");
    peek(3'd0, 16'h0555, "r0.rsvd");

    cyc(enc(4'd2, 3'd0, 3'd1), 1'b1, 1'b0, enc(4'd2, 3'd0, 3'd1), "ab.t0");
    cyc(16'hFFFF, 1'b0, 1'b0, 16'h0555, "ab.t1");
    @(negedge Clock);
    bus_if.DIN = 16'h1357;
    bus_if.Run = 1'b0;
    Reset = 1'b1;
    #1;
    chk("ab.done", {15'b0, bus_if.Done}, 16'h0);
    chk("ab.bus", bus_if.BusWires, 16'h1357);
    @(negedge Clock);
    Reset = 1'b0;
    cyc(16'h2468, 1'b0, 1'b0, 16'h2468, "ab.idle0");
    cyc(16'h2468, 1'b0, 1'b0, 16'h2468, "ab.idle1");
    cyc(16'h2468, 1'b0, 1'b0, 16'h2468, "ab.idle2");
    peek(3'd0, 16'h0000, "ab.r0");
    peek(3'd1, 16'h0000, "ab.r1");
    alu(4'd2, 3'd2, 3'd3, 16'h0000, 16'h0000, 16'h0000, "ab.add");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/processor_gen.md
PROCESSOR_GEN -- requirements
Module: processor_gen

Interface
REQ-001 Parameter N, default 16: data, register and bus width; legal range 10..32.
REQ-002 Parameter SHW, default 4: shift-amount field width; SHALL equal ceil(log2(N)).
REQ-003 The block SHALL have port Clock, input, 1 bit: the single clock; every state element updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port DIN, input, N bits: instruction word, or immediate data.
REQ-006 The block SHALL have port Run, input, 1 bit: start request, sampled only in step T0.
REQ-007 The block SHALL have port Done, output, 1 bit: asserted for exactly the single final cycle of each instruction.
REQ-008 The block SHALL have port BusWires, output, N bits: current value of the internal bus.

Function
REQ-009 Instruction fields SHALL be taken from DIN[N-1:N-10]: opcode = DIN[N-1:N-4], X = DIN[N-5:N-7], Y = DIN[N-8:N-10].
REQ-010 The block SHALL contain eight N-bit registers R0..R7, N-bit registers A and G, and a 10-bit IR.
REQ-011 The controller SHALL be a four-state FSM: T0 (fetch), T1, T2, T3.
REQ-012 In T0: if Run=1, IR <= instruction field and the FSM SHALL go to T1; if Run=0, it SHALL stay in T0 with no register writes.
REQ-013 T1, opcode 0 (mv): RX <= RY; Done=1; next state T0.
REQ-014 T1, opcode 1 (mvi): DIN in this cycle is the immediate; RX <= DIN; Done=1; next state T0.
REQ-015 T1, opcode 10 (mvnz): RX <= RY only when G != 0, otherwise no write; Done=1; next state T0.
REQ-016 T1, opcodes 2-9 (add, sub, or, slt, sll, srl, and, xor): A <= RX; next state T2.
REQ-017 T1, opcodes 11-15 (reserved): no write; Done=1; next state T0.
REQ-018 T2: G <= f(A, RY); next state T3.
REQ-019 T3: RX <= G; Done=1; next state T0.
REQ-020 Latency SHALL be 2 cycles (T0,T1) for mv/mvi/mvnz/reserved and 4 cycles (T0..T3) for ALU ops.
REQ-021 add/sub SHALL be modulo 2^N; carry and borrow are discarded.
REQ-022 slt SHALL be a signed two's-complement compare, producing G = 1 if A < RY, else 0.
REQ-023 sll/srl SHALL shift logically by RY[SHW-1:0]; result SHALL be 0 when RY >= N.
REQ-024 Bus source SHALL be exactly one of: RY (mv/mvnz T1, T2), DIN (mvi T1), RX (ALU T1), G (T3); DIN when none is selected.
REQ-025 Done SHALL be combinational from FSM state and IR, and SHALL be 0 in T0.
REQ-026 X = Y SHALL be legal; an ALU op uses the old RX value for both operands.
REQ-027 The Run level in T1..T3 SHALL be ignored; a new instruction SHALL be fetched in the T0 following Done when Run=1, with no idle gap.

Reset
REQ-028 Reset=1 SHALL, asynchronously, clear R0..R7, A, G and IR to 0 and force the FSM to T0, giving Done=0.
REQ-029 Reset during T1..T3 SHALL abort the instruction with no register write; after Reset falls, operation SHALL resume at T0.

Verification (N=16)
REQ-030 Run=1, DIN=0x1000 then 0x0005 -> R0=5 and Done=1 in the 2nd cycle; then DIN=0x1200 then 0x0003 -> R1=3.
REQ-031 With R0=5, R1=3, DIN=0x2040 (add R0,R1) -> Done only in the 4th cycle; R0=8, G=8.
REQ-032 With R2=0, R3=1, sub R2,R3 -> R2=0xFFFF; then with R4=0xFFFF, R5=1, slt R4,R5 -> R4=1.
REQ-033 With R6=1, R7=16, sll R6,R7 -> R6=0; with R7=4 -> R6=0x0010; srl by 4 -> R6=1.
REQ-034 With G=0, mvnz R0,R1 -> R0 unchanged and Done=1; with G=1 -> R0=R1.
REQ-035 Assert Reset in T2 of an add -> all registers 0 and Done=0 at once; Run=0 afterwards -> FSM stays in T0.
